// File: rtl/lp_deserializer_if.sv
// rtl/lp_deserializer_if.sv - serial-in / byte-out bundle for lp_deserializer
// Optional PARITY_ERR signal is present only with LP_DESER_PARITY_EN defined.
// Signals: SERIAL_IN (line, idle 0), PAR_OUT[7:0], VALID, FRAME_ERR,
//          FRAME_CNT[7:0], PARITY_ERR (parity build only).
// Modports: master drives SERIAL_IN; slave (the deserializer) drives the rest.
interface lp_deserializer_if;
    logic       SERIAL_IN;
    logic [7:0] PAR_OUT;
    logic       VALID;
    logic       FRAME_ERR;
    logic [7:0] FRAME_CNT;
`ifdef LP_DESER_PARITY_EN
    logic       PARITY_ERR;

    modport master (output SERIAL_IN, input PAR_OUT, VALID, FRAME_ERR, FRAME_CNT, PARITY_ERR);
    modport slave  (input SERIAL_IN, output PAR_OUT, VALID, FRAME_ERR, FRAME_CNT, PARITY_ERR);
`else
    modport master (output SERIAL_IN, input PAR_OUT, VALID, FRAME_ERR, FRAME_CNT);
    modport slave  (input SERIAL_IN, output PAR_OUT, VALID, FRAME_ERR, FRAME_CNT);
`endif
endinterface

// File: rtl/lp_deserializer.sv
// rtl/lp_deserializer.sv - start/stop framed serial-to-byte deserializer
// Frame: start 1, 8 data bits LSB first, [even parity], stop 0.
// Optional parity bit: define LP_DESER_PARITY_EN (adds PARITY state and PARITY_ERR).
// Ports: CLK       - clock, all state on posedge
//        RESET     - synchronous active-high reset
//        bus       - lp_deserializer_if.slave: SERIAL_IN in; PAR_OUT, VALID,
//                    FRAME_ERR, FRAME_CNT (and PARITY_ERR) out, all registered
module lp_deserializer (
    input  logic               CLK,
    input  logic               RESET,
    lp_deserializer_if.slave   bus
);

`ifdef LP_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] par_out_q, par_out_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
`ifdef LP_DESER_PARITY_EN
    logic       parity_err_q, parity_err_d;
    // Set when the received parity bit did not give even parity over the byte.
    logic       par_bad_q, par_bad_d;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_out_q    <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= 8'h00;
`ifdef LP_DESER_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_out_q    <= par_out_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
`ifdef LP_DESER_PARITY_EN
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_out_d    = par_out_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;
`ifdef LP_DESER_PARITY_EN
        parity_err_d = 1'b0;
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.SERIAL_IN) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                shift_d[bit_cnt_q] = bus.SERIAL_IN;
                bit_cnt_d          = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
`ifdef LP_DESER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef LP_DESER_PARITY_EN
            PARITY: begin
                par_bad_d = (^shift_q) ^ bus.SERIAL_IN;
                state_d   = STOP;
            end
`endif
            STOP: begin
                // Always back to IDLE: a 1 here is a framing error, never a start bit.
                state_d = IDLE;
                if (bus.SERIAL_IN) begin
                    frame_err_d = 1'b1;
                end
`ifdef LP_DESER_PARITY_EN
                else if (par_bad_q) begin
                    parity_err_d = 1'b1;
                end
`endif
                else begin
                    par_out_d   = shift_q;
                    valid_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.PAR_OUT    = par_out_q;
    assign bus.VALID      = valid_q;
    assign bus.FRAME_ERR  = frame_err_q;
    assign bus.FRAME_CNT  = frame_cnt_q;
`ifdef LP_DESER_PARITY_EN
    assign bus.PARITY_ERR = parity_err_q;
`endif

endmodule

// File: tb/tb_lp_deserializer.sv
// tb/tb_lp_deserializer.sv - directed self-checking bench for lp_deserializer
module tb_lp_deserializer;

`ifdef LP_DESER_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    logic clk;
    logic rst;
    lp_deserializer_if bus_if ();

    lp_deserializer dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse observer: sampled 1 ns after each posedge, read by tasks at negedge.
    int cyc         = 0;
    int valid_seen  = 0;
    int ferr_seen   = 0;
    int perr_seen   = 0;
    int overlap     = 0;
    int last_valid  = 0;
    int prev_valid  = 0;

    always @(posedge clk) begin
        logic pe;
        #1;
        cyc = cyc + 1;
`ifdef LP_DESER_PARITY_EN
        pe = bus_if.PARITY_ERR;
`else
        pe = 1'b0;
`endif
        if (bus_if.VALID === 1'b1) begin
            valid_seen = valid_seen + 1;
            prev_valid = last_valid;
            last_valid = cyc;
        end
        if (bus_if.FRAME_ERR === 1'b1) ferr_seen = ferr_seen + 1;
        if (pe === 1'b1) perr_seen = perr_seen + 1;
        if ((32'(bus_if.VALID) + 32'(bus_if.FRAME_ERR) + 32'(pe)) > 1) overlap = overlap + 1;
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus_if.SERIAL_IN = b;
    endtask

    // Data bits, correct parity (parity build) and stop; caller sends the start bit.
    task automatic send_body(input logic [7:0] data, input logic stop);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef LP_DESER_PARITY_EN
        send_bit(^data);
`endif
        send_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b1);
        send_body(data, stop);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.SERIAL_IN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus_if.PAR_OUT !== 8'h00) $display("FAIL reset_par_out: got %0h expected 0", bus_if.PAR_OUT); else n_pass++;
        n_checks++; if (bus_if.VALID !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", bus_if.VALID); else n_pass++;
        n_checks++; if (bus_if.FRAME_ERR !== 1'b0) $display("FAIL reset_frame_err: got %0b expected 0", bus_if.FRAME_ERR); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'h00) $display("FAIL reset_frame_cnt: got %0h expected 0", bus_if.FRAME_CNT); else n_pass++;
    endtask

    task automatic test_single();
        int v0;
        do_reset();
        v0 = valid_seen;
        send_frame(8'hAF, 1'b0);
        // Stop bit is on the line but not yet sampled.
        n_checks++; if (bus_if.VALID !== 1'b0) $display("FAIL single_valid_early: got %0b expected 0", bus_if.VALID); else n_pass++;
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.VALID !== 1'b1) $display("FAIL single_valid: got %0b expected 1", bus_if.VALID); else n_pass++;
        n_checks++; if (bus_if.PAR_OUT !== 8'hAF) $display("FAIL single_par_out: got %0h expected af", bus_if.PAR_OUT); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd1) $display("FAIL single_frame_cnt: got %0d expected 1", bus_if.FRAME_CNT); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus_if.VALID !== 1'b0) $display("FAIL single_valid_one_cycle: got %0b expected 0", bus_if.VALID); else n_pass++;
        n_checks++; if (valid_seen - v0 !== 1) $display("FAIL single_valid_count: got %0d expected 1", valid_seen - v0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int v0;
        do_reset();
        v0 = valid_seen;
        send_frame(8'hAF, 1'b0);
        send_frame(8'h50, 1'b0);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        @(negedge clk);
        n_checks++; if (valid_seen - v0 !== 2) $display("FAIL b2b_valid_count: got %0d expected 2", valid_seen - v0); else n_pass++;
        n_checks++; if (last_valid - prev_valid !== FRAME_LEN) $display("FAIL b2b_spacing: got %0d expected %0d", last_valid - prev_valid, FRAME_LEN); else n_pass++;
        n_checks++; if (bus_if.PAR_OUT !== 8'h50) $display("FAIL b2b_par_out: got %0h expected 50", bus_if.PAR_OUT); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd2) $display("FAIL b2b_frame_cnt: got %0d expected 2", bus_if.FRAME_CNT); else n_pass++;
    endtask

    // Runs after test_back_to_back: PAR_OUT=0x50, FRAME_CNT=2. The bad stop bit
    // is followed immediately by the next start bit, so a stop-as-start bug misaligns 0x11.
    task automatic test_frame_err();
        int v0, f0;
        v0 = valid_seen;
        f0 = ferr_seen;
        send_frame(8'h3C, 1'b1);
        @(negedge clk);
        n_checks++; if (bus_if.FRAME_ERR !== 1'b1) $display("FAIL ferr_pulse: got %0b expected 1", bus_if.FRAME_ERR); else n_pass++;
        n_checks++; if (bus_if.VALID !== 1'b0) $display("FAIL ferr_no_valid: got %0b expected 0", bus_if.VALID); else n_pass++;
        n_checks++; if (bus_if.PAR_OUT !== 8'h50) $display("FAIL ferr_par_out_hold: got %0h expected 50", bus_if.PAR_OUT); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd2) $display("FAIL ferr_frame_cnt_hold: got %0d expected 2", bus_if.FRAME_CNT); else n_pass++;
        bus_if.SERIAL_IN = 1'b1;
        send_body(8'h11, 1'b0);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.PAR_OUT !== 8'h11) $display("FAIL ferr_next_par_out: got %0h expected 11", bus_if.PAR_OUT); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd3) $display("FAIL ferr_next_frame_cnt: got %0d expected 3", bus_if.FRAME_CNT); else n_pass++;
        @(negedge clk);
        n_checks++; if (ferr_seen - f0 !== 1) $display("FAIL ferr_count: got %0d expected 1", ferr_seen - f0); else n_pass++;
        n_checks++; if (valid_seen - v0 !== 1) $display("FAIL ferr_valid_count: got %0d expected 1", valid_seen - v0); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        logic [7:0] d;
        d = 8'h3C;
        v0 = valid_seen;
        f0 = ferr_seen;
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        do_reset();
        n_checks++; if (bus_if.PAR_OUT !== 8'h00) $display("FAIL midrst_par_out: got %0h expected 0", bus_if.PAR_OUT); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'h00) $display("FAIL midrst_frame_cnt: got %0h expected 0", bus_if.FRAME_CNT); else n_pass++;
        repeat (12) @(negedge clk);
        n_checks++; if (valid_seen - v0 !== 0) $display("FAIL midrst_no_valid: got %0d expected 0", valid_seen - v0); else n_pass++;
        n_checks++; if (ferr_seen - f0 !== 0) $display("FAIL midrst_no_ferr: got %0d expected 0", ferr_seen - f0); else n_pass++;
        send_frame(8'hA5, 1'b0);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.VALID !== 1'b1) $display("FAIL midrst_next_valid: got %0b expected 1", bus_if.VALID); else n_pass++;
        n_checks++; if (bus_if.PAR_OUT !== 8'hA5) $display("FAIL midrst_next_par_out: got %0h expected a5", bus_if.PAR_OUT); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd1) $display("FAIL midrst_next_frame_cnt: got %0d expected 1", bus_if.FRAME_CNT); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) send_frame(i[7:0], 1'b0);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd255) $display("FAIL wrap_cnt_255: got %0d expected 255", bus_if.FRAME_CNT); else n_pass++;
        n_checks++; if (bus_if.PAR_OUT !== 8'hFE) $display("FAIL wrap_par_out_255: got %0h expected fe", bus_if.PAR_OUT); else n_pass++;
        send_frame(8'hFF, 1'b0);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.VALID !== 1'b1) $display("FAIL wrap_valid_256: got %0b expected 1", bus_if.VALID); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd0) $display("FAIL wrap_cnt_0: got %0d expected 0", bus_if.FRAME_CNT); else n_pass++;
    endtask

`ifdef LP_DESER_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        d = 8'hAF;
        do_reset();
        // 0xAF has six ones, so even parity needs 0; send 1 first.
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.PARITY_ERR !== 1'b1) $display("FAIL par_err_pulse: got %0b expected 1", bus_if.PARITY_ERR); else n_pass++;
        n_checks++; if (bus_if.VALID !== 1'b0) $display("FAIL par_err_no_valid: got %0b expected 0", bus_if.VALID); else n_pass++;
        n_checks++; if (bus_if.FRAME_CNT !== 8'd0) $display("FAIL par_err_cnt_hold: got %0d expected 0", bus_if.FRAME_CNT); else n_pass++;
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.VALID !== 1'b1) $display("FAIL par_ok_valid: got %0b expected 1", bus_if.VALID); else n_pass++;
        n_checks++; if (bus_if.PAR_OUT !== 8'hAF) $display("FAIL par_ok_par_out: got %0h expected af", bus_if.PAR_OUT); else n_pass++;
        // Bad parity and bad stop together: framing error only.
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk); bus_if.SERIAL_IN = 1'b0;
        n_checks++; if (bus_if.FRAME_ERR !== 1'b1 || bus_if.PARITY_ERR !== 1'b0) $display("FAIL par_stop_err: got ferr=%0b perr=%0b expected ferr=1 perr=0", bus_if.FRAME_ERR, bus_if.PARITY_ERR); else n_pass++;
    endtask
`endif

    task automatic test_exclusive_pulses();
        @(negedge clk);
        n_checks++; if (overlap !== 0) $display("FAIL pulse_overlap: got %0d expected 0", overlap); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.SERIAL_IN = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_reset_mid_frame();
        test_wrap();
`ifdef LP_DESER_PARITY_EN
        test_parity();
`endif
        test_exclusive_pulses();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
